// File: rtl/alu_result_tx_if.sv
// Handshake and serial-line bundle between the slave ALU and the result transmitter.
interface alu_result_tx_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] result;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;
  logic             ready;
  logic             tx;
  logic             done;

  modport master (
    output start, result, N, Z, C, V,
    input  ready, tx, done
  );

  modport slave (
    input  start, result, N, Z, C, V,
    output ready, tx, done
  );
endinterface

// File: rtl/alu_result_tx.sv
// Serial transmitter for one ALU result plus N/Z/C/V flags.
// Frame: start bit, payload LSB-first, even parity, stop bit.
//
// state  | meaning
// IDLE   | line high, ready for a new result
// START  | start bit (low)
// DATA   | payload bits: result[0..WIDTH-1], then N, Z, C, V
// PARITY | even-parity bit over the payload
// STOP   | stop bit (high); done pulses in its last cycle
module alu_result_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_result_tx_if.slave  bus
);
  localparam int PW = WIDTH + 4;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(PW);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(PW - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [PW-1:0]   shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            bit_end;
  logic            accept;
  logic [PW-1:0]   payload;

  assign bit_end = (cnt_q == CNT_LAST);
  assign payload = {bus.V, bus.C, bus.Z, bus.N, bus.result};
  // A held start is also taken at the end of STOP so frames run back-to-back.
  assign accept  = bus.start && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_DONE) done_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
    if (accept) begin
      state_d = START;
      cnt_d   = '0;
      shreg_d = payload;
      par_d   = ^payload;
      tx_d    = 1'b0;
      ready_d = 1'b0;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx with WIDTH=4, CLKS_PER_BIT=4.
module tb_alu_result_tx;
  localparam int WIDTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = (WIDTH + 7) * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_result_tx_if #(.WIDTH(WIDTH)) bus ();

  alu_result_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] r, input logic n, input logic z, input logic c, input logic v);
    bus.result = r;
    bus.N = n;
    bus.Z = z;
    bus.C = c;
    bus.V = v;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_val({name, "_tx"}, bus.tx, 1);
      check_val({name, "_ready"}, bus.ready, 1);
      check_val({name, "_done"}, bus.done, 0);
      tick();
    end
  endtask

  // Raises start on an idle DUT; returns just after the acceptance edge.
  task automatic accept_frame(input string name);
    check_val({name, "_accept_ready"}, bus.ready, 1);
    bus.start = 1'b1;
    tick();
  endtask

  // exp[0] is the start bit, exp[10] the stop bit. nf is {N,Z,C,V}.
  task automatic frame_check(input string name, input logic [10:0] exp, input bit drop_start,
                             input bit disturb, input bit load_nxt,
                             input logic [3:0] nr, input logic [3:0] nf);
    for (int cyc = 1; cyc <= FRAME; cyc++) begin
      if (cyc == 1 && drop_start) bus.start = 1'b0;
      if (disturb && cyc == 10) begin
        bus.start = 1'b1;
        set_in(4'b1010, 1'b1, 1'b1, 1'b1, 1'b1);
      end
      if (disturb && cyc == 11) bus.start = 1'b0;
      if (load_nxt && cyc == 40) set_in(nr, nf[3], nf[2], nf[1], nf[0]);
      check_val({name, "_tx"}, bus.tx, exp[(cyc - 1) / CPB]);
      check_val({name, "_ready"}, bus.ready, 0);
      check_val({name, "_done"}, bus.done, (cyc == FRAME));
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    set_in(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_tx", bus.tx, 1);
    check_val("rst_ready", bus.ready, 1);
    check_val("rst_done", bus.done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_idle("idle", 20);

    // 0110, C=1: payload has three ones, parity 1
    set_in(4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    accept_frame("single");
    frame_check("single", 11'b11010001100, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check_idle("after_single", 3);

    set_in(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    accept_frame("zflag");
    frame_check("zflag", 11'b11001000000, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check_idle("after_zflag", 2);

    set_in(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    accept_frame("par0");
    frame_check("par0", 11'b10000011110, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check_idle("after_par0", 2);

    // 0101, N=1, V=1: four ones, parity 0; mid-frame start and input change ignored
    set_in(4'b0101, 1'b1, 1'b0, 1'b0, 1'b1);
    accept_frame("ignored");
    frame_check("ignored", 11'b10100101010, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    check_idle("no_second", 12);

    // start held across two frames: second frame carries the Z-flag vector
    set_in(4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    accept_frame("b2b");
    frame_check("b2b_a", 11'b11010001100, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
    frame_check("b2b_b", 11'b11001000000, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check_idle("after_b2b", 4);

    // result bit 2 is 0, so tx is low during DATA bit 2 when reset hits
    set_in(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    accept_frame("midrst");
    bus.start = 1'b0;
    repeat (13) tick();
    check_val("midrst_bit2_tx", bus.tx, 0);
    check_val("midrst_bit2_ready", bus.ready, 0);
    rst_n = 1'b0;
    #1;
    check_val("midrst_async_tx", bus.tx, 1);
    check_val("midrst_async_ready", bus.ready, 1);
    check_val("midrst_async_done", bus.done, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_idle("post_rst", 3);
    set_in(4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    accept_frame("recover");
    frame_check("recover", 11'b11010001100, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check_idle("after_recover", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
